// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt priority engine.
//   DEFAULT_NUM_IRQ : default channel count
//   idx_width()     : channel index width for a given channel count
//   spurious_idx()  : vector index reported for an ack with nothing pending
//   wrap_add()      : modular add used to walk the rotating priority order
//   prio_rank()     : position of a channel in the priority order (0 = highest)
package interrupt_pkg;

  localparam int DEFAULT_NUM_IRQ = 8;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int spurious_idx(input int n);
    return n - 1;
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

  // The channel just after lowest_prio has rank 0.
  function automatic int prio_rank(input int ch, input int lp, input int n);
    return (ch - lp - 1 + n) % n;
  endfunction

endpackage

// File: rtl/interrupt_priority_engine_if.sv
// Command/response bus between the control logic and the priority engine.
//   master : control logic (drives ack, EOI and set-priority commands)
//   slave  : priority engine (drives int_req and the vector response)
// Handshake: every command (ack, eoi_valid, set_prio_valid) is a single-cycle
// pulse that is always accepted; there is no ready. int_req is the engine's
// "request valid"; an ack while int_req=1 takes that request, an ack while
// int_req=0 is answered as spurious. vector_valid pulses exactly once, the
// cycle after every ack, with vector_idx/spurious qualified by it.
interface interrupt_priority_engine_if
  import interrupt_pkg::*;
#(
  parameter int NUM_IRQ = DEFAULT_NUM_IRQ
) ();

  localparam int IDX_W = idx_width(NUM_IRQ);

  logic             ack;
  logic             eoi_valid;
  logic             eoi_specific;
  logic [IDX_W-1:0] eoi_level;
  logic             set_prio_valid;
  logic [IDX_W-1:0] set_prio_level;
  logic             int_req;
  logic             vector_valid;
  logic [IDX_W-1:0] vector_idx;
  logic             spurious;

  modport master (
    output ack, eoi_valid, eoi_specific, eoi_level, set_prio_valid, set_prio_level,
    input  int_req, vector_valid, vector_idx, spurious
  );

  modport slave (
    input  ack, eoi_valid, eoi_specific, eoi_level, set_prio_valid, set_prio_level,
    output int_req, vector_valid, vector_idx, spurious
  );

endinterface

// File: rtl/interrupt_priority_engine_encoder.sv
// rotating_priority_encoder: combinational search for the highest-priority set
// bit of vec, where priority starts at lowest_prio+1 and ascends with wrap.
//   vec         : candidate bits
//   lowest_prio : current lowest-priority channel
//   found       : any bit set
//   idx         : highest-priority set bit (0 when none)
module rotating_priority_encoder
  import interrupt_pkg::*;
#(
  parameter int NUM_IRQ = DEFAULT_NUM_IRQ,
  parameter int IDX_W   = idx_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [IDX_W-1:0]   lowest_prio,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] ch;

  // Walk from lowest priority (k=NUM_IRQ) to highest (k=1); the last hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    ch    = '0;
    for (int k = NUM_IRQ; k >= 1; k--) begin
      ch = IDX_W'(wrap_add(int'(lowest_prio), k, NUM_IRQ));
      if (vec[ch]) begin
        found = 1'b1;
        idx   = ch;
      end
    end
  end

endmodule

// File: rtl/interrupt_priority_engine.sv
// interrupt_priority_engine: 8259A-style IRR/ISR priority resolver.
//   clk, rst_n  : clock, asynchronous active-low reset
//   irq_in      : raw request lines
//   level_mode  : 1 = level-triggered, 0 = rising-edge-triggered
//   mask        : 1 = channel masked
//   rotate_mode : rotate priority on every EOI / auto-EOI
//   auto_eoi    : do not set the ISR bit on acknowledge
//   bus         : ack / EOI / set-priority commands, int_req and vector response
//   irr, isr    : request and in-service registers
//   lowest_prio : current lowest-priority channel
module interrupt_priority_engine
  import interrupt_pkg::*;
#(
  parameter int NUM_IRQ = DEFAULT_NUM_IRQ,
  parameter int IDX_W   = idx_width(NUM_IRQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_IRQ-1:0]   irq_in,
  input  logic                 level_mode,
  input  logic [NUM_IRQ-1:0]   mask,
  input  logic                 rotate_mode,
  input  logic                 auto_eoi,
  interrupt_priority_engine_if.slave bus,
  output logic [NUM_IRQ-1:0]   irr,
  output logic [NUM_IRQ-1:0]   isr,
  output logic [IDX_W-1:0]     lowest_prio
);

  localparam logic [IDX_W-1:0] SPUR_IDX = IDX_W'(spurious_idx(NUM_IRQ));

  logic [NUM_IRQ-1:0] irq_q;
  logic               int_req_q;
  logic [IDX_W-1:0]   pend_idx;
  logic               vector_valid_q;
  logic [IDX_W-1:0]   vector_idx_q;
  logic               spurious_q;

  logic               cand_found, isr_found;
  logic [IDX_W-1:0]   cand_idx, isr_idx;
  logic               pending;
  logic               ack_taken;
  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] irr_next, isr_next;
  logic [IDX_W-1:0]   lp_next;

  rotating_priority_encoder #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_cand_enc (
    .vec         (irr & ~mask),
    .lowest_prio (lowest_prio),
    .found       (cand_found),
    .idx         (cand_idx)
  );

  // Masked channels still take part here: an in-service masked level blocks.
  rotating_priority_encoder #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_isr_enc (
    .vec         (isr),
    .lowest_prio (lowest_prio),
    .found       (isr_found),
    .idx         (isr_idx)
  );

  always_comb begin
    pending   = cand_found &&
                (!isr_found ||
                 prio_rank(int'(cand_idx), int'(lowest_prio), NUM_IRQ) <
                 prio_rank(int'(isr_idx), int'(lowest_prio), NUM_IRQ));
    ack_taken = bus.ack & int_req_q;
    edges     = irq_in & ~irq_q;

    irr_next = level_mode ? irq_in : (irr | edges);
    // A fresh edge on the acked channel in edge mode is a new request: keep it.
    if (ack_taken && (level_mode || !edges[pend_idx])) irr_next[pend_idx] = 1'b0;

    // EOI acts on the pre-ack ISR.
    isr_next = isr;
    lp_next  = lowest_prio;
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        if (int'(bus.eoi_level) < NUM_IRQ) begin
          isr_next[bus.eoi_level] = 1'b0;
          if (rotate_mode) lp_next = bus.eoi_level;
        end
      end else if (isr_found) begin
        isr_next[isr_idx] = 1'b0;
        if (rotate_mode) lp_next = isr_idx;
      end
    end

    // Applied after EOI so the ack's ISR set wins on the same bit.
    if (ack_taken) begin
      if (!auto_eoi) isr_next[pend_idx] = 1'b1;
      else if (rotate_mode) lp_next = pend_idx;
    end

    if (bus.set_prio_valid && int'(bus.set_prio_level) < NUM_IRQ)
      lp_next = bus.set_prio_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q          <= '0;
      irr            <= '0;
      isr            <= '0;
      lowest_prio    <= SPUR_IDX;
      int_req_q      <= 1'b0;
      pend_idx       <= '0;
      vector_valid_q <= 1'b0;
      vector_idx_q   <= '0;
      spurious_q     <= 1'b0;
    end else begin
      irq_q          <= irq_in;
      irr            <= irr_next;
      isr            <= isr_next;
      lowest_prio    <= lp_next;
      int_req_q      <= ack_taken ? 1'b0 : pending;
      pend_idx       <= cand_idx;
      vector_valid_q <= bus.ack;
      spurious_q     <= bus.ack & ~int_req_q;
      if (bus.ack) vector_idx_q <= ack_taken ? pend_idx : SPUR_IDX;
    end
  end

  assign bus.int_req      = int_req_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.vector_idx   = vector_idx_q;
  assign bus.spurious     = spurious_q;

endmodule

// File: tb/tb_interrupt_priority_engine.sv
module tb_interrupt_priority_engine;
  import interrupt_pkg::*;

  localparam int N  = 8;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]  irq_in, mask;
  logic          level_mode, rotate_mode, auto_eoi;
  logic [N-1:0]  irr, isr;
  logic [IW-1:0] lowest_prio;

  interrupt_priority_engine_if #(.NUM_IRQ(N)) bus ();

  interrupt_priority_engine #(.NUM_IRQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_in      (irq_in),
    .level_mode  (level_mode),
    .mask        (mask),
    .rotate_mode (rotate_mode),
    .auto_eoi    (auto_eoi),
    .bus         (bus.slave),
    .irr         (irr),
    .isr         (isr),
    .lowest_prio (lowest_prio)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0]  m_irr, m_isr, m_irq_q;
  logic          m_int_req, m_vv, m_spur;
  int            m_pend, m_vidx, m_lp;
  logic [IW:0]   exp_q[$];

  // First set bit of v walking the priority order, -1 if none.
  function automatic int top_ch(input logic [N-1:0] v, input int lp);
    for (int r = 0; r < N; r++) begin
      int ch;
      ch = (lp + 1 + r) % N;
      if (v[IW'(ch)]) return ch;
    end
    return -1;
  endfunction

  // Walk the order; whichever of an ISR bit or a candidate bit is met first decides.
  function automatic logic would_interrupt(input logic [N-1:0] cand, input logic [N-1:0] srv,
                                           input int lp);
    for (int r = 0; r < N; r++) begin
      int ch;
      ch = (lp + 1 + r) % N;
      if (srv[IW'(ch)]) return 1'b0;
      if (cand[IW'(ch)]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_irq_q = '0;
    m_int_req = 1'b0; m_vv = 1'b0; m_spur = 1'b0;
    m_pend = 0; m_vidx = 0; m_lp = N - 1;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] edges, n_irr, n_isr;
    logic taken, pend;
    int n_lp, t, w;
    taken = bus.ack && m_int_req;
    edges = irq_in & ~m_irq_q;
    n_irr = level_mode ? irq_in : (m_irr | edges);
    if (taken && (level_mode || !edges[IW'(m_pend)])) n_irr[IW'(m_pend)] = 1'b0;
    n_isr = m_isr;
    n_lp  = m_lp;
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        n_isr[bus.eoi_level] = 1'b0;
        if (rotate_mode) n_lp = int'(bus.eoi_level);
      end else begin
        t = top_ch(m_isr, m_lp);
        if (t >= 0) begin
          n_isr[IW'(t)] = 1'b0;
          if (rotate_mode) n_lp = t;
        end
      end
    end
    if (taken) begin
      if (!auto_eoi) n_isr[IW'(m_pend)] = 1'b1;
      else if (rotate_mode) n_lp = m_pend;
    end
    if (bus.set_prio_valid) n_lp = int'(bus.set_prio_level);

    pend = would_interrupt(m_irr & ~mask, m_isr, m_lp);
    w    = top_ch(m_irr & ~mask, m_lp);

    m_vv   = bus.ack;
    m_spur = bus.ack && !m_int_req;
    if (taken) m_vidx = m_pend;
    else if (bus.ack) m_vidx = N - 1;
    if (bus.ack) exp_q.push_back({m_spur, IW'(m_vidx)});

    m_int_req = taken ? 1'b0 : pend;
    if (w >= 0) m_pend = w;
    m_irr = n_irr; m_isr = n_isr; m_lp = n_lp; m_irq_q = irq_in;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.ack = 1'b0; bus.eoi_valid = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = '0;
    bus.set_prio_valid = 1'b0; bus.set_prio_level = '0;
  endtask

  // Inputs change at the falling edge; DUT and model both see them at the rising edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle_inputs();
    irq_in = '0; mask = '0; level_mode = 1'b0; rotate_mode = 1'b0; auto_eoi = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
  endtask

  task automatic compare_model();
    logic [IW:0] e;
    check("rand.int_req", 32'(bus.int_req), 32'(m_int_req));
    check("rand.vector_valid", 32'(bus.vector_valid), 32'(m_vv));
    check("rand.vector_idx", 32'(bus.vector_idx), 32'(m_vidx));
    check("rand.irr", 32'(irr), 32'(m_irr));
    check("rand.isr", 32'(isr), 32'(m_isr));
    check("rand.lowest_prio", 32'(lowest_prio), 32'(m_lp));
    if (bus.vector_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rand.sb_vector", 32'({bus.spurious, bus.vector_idx}), 32'(e));
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0]  irq;
    logic          ack;
    logic          eoi;
    logic          exp_int_req;
    logic          exp_vv;
    logic [IW-1:0] exp_vidx;
    logic [N-1:0]  exp_isr;
    logic [N-1:0]  exp_irr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Edge mode, reset priorities: irq 0x24 -> ch2 first, ch5 only after EOI.
    tbl[0] = '{irq: 8'h24, ack: 1'b0, eoi: 1'b0, exp_int_req: 1'b0, exp_vv: 1'b0, exp_vidx: 3'd0, exp_isr: 8'h00, exp_irr: 8'h24};
    tbl[1] = '{irq: 8'h24, ack: 1'b0, eoi: 1'b0, exp_int_req: 1'b1, exp_vv: 1'b0, exp_vidx: 3'd0, exp_isr: 8'h00, exp_irr: 8'h24};
    tbl[2] = '{irq: 8'h24, ack: 1'b1, eoi: 1'b0, exp_int_req: 1'b0, exp_vv: 1'b1, exp_vidx: 3'd2, exp_isr: 8'h04, exp_irr: 8'h20};
    tbl[3] = '{irq: 8'h24, ack: 1'b0, eoi: 1'b0, exp_int_req: 1'b0, exp_vv: 1'b0, exp_vidx: 3'd2, exp_isr: 8'h04, exp_irr: 8'h20};
    tbl[4] = '{irq: 8'h24, ack: 1'b0, eoi: 1'b1, exp_int_req: 1'b0, exp_vv: 1'b0, exp_vidx: 3'd2, exp_isr: 8'h00, exp_irr: 8'h20};
    tbl[5] = '{irq: 8'h24, ack: 1'b0, eoi: 1'b0, exp_int_req: 1'b1, exp_vv: 1'b0, exp_vidx: 3'd2, exp_isr: 8'h00, exp_irr: 8'h20};
    tbl[6] = '{irq: 8'h24, ack: 1'b1, eoi: 1'b0, exp_int_req: 1'b0, exp_vv: 1'b1, exp_vidx: 3'd5, exp_isr: 8'h20, exp_irr: 8'h00};

    apply_reset();
    check("reset.irr", 32'(irr), 32'h0);
    check("reset.isr", 32'(isr), 32'h0);
    check("reset.int_req", 32'(bus.int_req), 32'h0);
    check("reset.vector_valid", 32'(bus.vector_valid), 32'h0);
    check("reset.vector_idx", 32'(bus.vector_idx), 32'h0);
    check("reset.spurious", 32'(bus.spurious), 32'h0);
    check("reset.lowest_prio", 32'(lowest_prio), 32'd7);

    for (int i = 0; i < 7; i++) begin
      irq_in = tbl[i].irq; bus.ack = tbl[i].ack; bus.eoi_valid = tbl[i].eoi;
      tick();
      bus.ack = 1'b0; bus.eoi_valid = 1'b0;
      check($sformatf("tbl%0d.int_req", i), 32'(bus.int_req), 32'(tbl[i].exp_int_req));
      check($sformatf("tbl%0d.vector_valid", i), 32'(bus.vector_valid), 32'(tbl[i].exp_vv));
      check($sformatf("tbl%0d.vector_idx", i), 32'(bus.vector_idx), 32'(tbl[i].exp_vidx));
      check($sformatf("tbl%0d.spurious", i), 32'(bus.spurious), 32'h0);
      check($sformatf("tbl%0d.isr", i), 32'(isr), 32'(tbl[i].exp_isr));
      check($sformatf("tbl%0d.irr", i), 32'(irr), 32'(tbl[i].exp_irr));
    end

    // Fully nested: ch4 in service blocks ch6 but not ch1.
    apply_reset();
    irq_in = 8'h10; tick(); tick();
    check("nest.int_req_ch4", 32'(bus.int_req), 32'h1);
    pulse_ack();
    check("nest.isr_ch4", 32'(isr), 32'h10);
    irq_in = 8'h50; tick(); tick();
    check("nest.blocked_ch6", 32'(bus.int_req), 32'h0);
    check("nest.irr_ch6", 32'(irr), 32'h40);
    irq_in = 8'h52; tick(); tick();
    check("nest.int_req_ch1", 32'(bus.int_req), 32'h1);
    pulse_ack();
    check("nest.vector_ch1", 32'(bus.vector_idx), 32'd1);
    check("nest.isr_nested", 32'(isr), 32'h12);

    // Rotation on non-specific EOI.
    apply_reset();
    rotate_mode = 1'b1;
    irq_in = 8'h08; tick(); tick(); pulse_ack();
    check("rot.vector_ch3", 32'(bus.vector_idx), 32'd3);
    bus.eoi_valid = 1'b1; tick(); bus.eoi_valid = 1'b0;
    check("rot.lowest_prio", 32'(lowest_prio), 32'd3);
    check("rot.isr_clear", 32'(isr), 32'h0);
    irq_in = 8'h15; tick(); tick();
    check("rot.int_req", 32'(bus.int_req), 32'h1);
    pulse_ack();
    check("rot.vector_ch4", 32'(bus.vector_idx), 32'd4);

    // set_prio wins over a simultaneous specific EOI rotation.
    apply_reset();
    rotate_mode = 1'b1;
    irq_in = 8'h04; tick(); tick(); pulse_ack();
    check("prio.isr_ch2", 32'(isr), 32'h04);
    bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'd2;
    bus.set_prio_valid = 1'b1; bus.set_prio_level = 3'd5;
    tick(); idle_inputs();
    check("prio.lowest_prio", 32'(lowest_prio), 32'd5);
    check("prio.isr_clear", 32'(isr), 32'h0);

    // Level mode, request withdrawn before ack -> spurious.
    apply_reset();
    level_mode = 1'b1;
    irq_in = 8'h80; tick(); tick();
    check("lvl.int_req", 32'(bus.int_req), 32'h1);
    irq_in = 8'h00; tick();
    check("lvl.irr_drop", 32'(irr), 32'h0);
    check("lvl.int_req_lag", 32'(bus.int_req), 32'h1);
    tick();
    check("lvl.int_req_drop", 32'(bus.int_req), 32'h0);
    pulse_ack();
    check("lvl.vector_valid", 32'(bus.vector_valid), 32'h1);
    check("lvl.spurious", 32'(bus.spurious), 32'h1);
    check("lvl.vector_idx", 32'(bus.vector_idx), 32'd7);
    check("lvl.isr", 32'(isr), 32'h0);

    // Auto-EOI with mask, then reset in the middle of an ack.
    apply_reset();
    auto_eoi = 1'b1; mask = 8'hFE;
    irq_in = 8'h03; tick(); tick();
    check("aeoi.int_req", 32'(bus.int_req), 32'h1);
    pulse_ack();
    check("aeoi.vector_ch0", 32'(bus.vector_idx), 32'd0);
    check("aeoi.isr", 32'(isr), 32'h0);
    check("aeoi.irr", 32'(irr), 32'h02);
    tick();
    check("aeoi.masked_ch1", 32'(bus.int_req), 32'h0);
    mask = 8'h00; tick();
    check("aeoi.unmasked_ch1", 32'(bus.int_req), 32'h1);
    bus.ack = 1'b1; rst_n = 1'b0;
    tick();
    bus.ack = 1'b0;
    check("rstmid.irr", 32'(irr), 32'h0);
    check("rstmid.isr", 32'(isr), 32'h0);
    check("rstmid.int_req", 32'(bus.int_req), 32'h0);
    check("rstmid.vector_valid", 32'(bus.vector_valid), 32'h0);
    check("rstmid.vector_idx", 32'(bus.vector_idx), 32'h0);
    check("rstmid.spurious", 32'(bus.spurious), 32'h0);
    check("rstmid.lowest_prio", 32'(lowest_prio), 32'd7);
    rst_n = 1'b1;
    tick();
    check("rstmid.vv_dropped", 32'(bus.vector_valid), 32'h0);
    check("rstmid.edge_reg_cleared", 32'(irr), 32'h03);

    // Randomized run against the model.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      if ($urandom_range(0, 63) == 0) mask = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 255) == 0) level_mode = ~level_mode;
      if ($urandom_range(0, 127) == 0) rotate_mode = ~rotate_mode;
      if ($urandom_range(0, 127) == 0) auto_eoi = ~auto_eoi;
      bus.ack            = ($urandom_range(0, 3) == 0);
      bus.eoi_valid      = ($urandom_range(0, 5) == 0);
      bus.eoi_specific   = 1'($urandom_range(0, 1));
      bus.eoi_level      = IW'($urandom_range(0, N - 1));
      bus.set_prio_valid = ($urandom_range(0, 15) == 0);
      bus.set_prio_level = IW'($urandom_range(0, N - 1));
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
      compare_model();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
    compare_model();
    check("rand.sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_priority_engine.md
# interrupt_priority_engine

Parametrised, registered interrupt priority engine for the 8259A-style controller. It latches N request lines into an IRR (Interrupt Request Register) and tracks in-service levels in an ISR (In-Service Register). It resolves the highest-priority unmasked request under fully-nested or rotating priority, and services acknowledge and EOI (End Of Interrupt) commands from the control logic. It sits between the IR pins and the control/bus-interface logic.

## Interface
- NUM_IRQ, 8: number of interrupt channels (2..32).
- IDX_W, $clog2(NUM_IRQ): channel index width (derived).
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw request lines, synchronous to clk.
- level_mode  in  1  1 = level-triggered, 0 = rising-edge-triggered.
- mask  in  NUM_IRQ  1 = channel masked.
- rotate_mode  in  1  1 = automatic rotation on every EOI/auto-EOI.
- auto_eoi  in  1  1 = ISR bit not set on acknowledge.
- ack  in  1  one-cycle acknowledge pulse.
- eoi_valid  in  1  one-cycle EOI command.
- eoi_specific  in  1  1 = specific EOI on eoi_level; 0 = non-specific.
- eoi_level  in  IDX_W  target channel for specific EOI.
- set_prio_valid  in  1  one-cycle set-lowest-priority command.
- set_prio_level  in  IDX_W  new lowest-priority channel.
- int_req  out  1  registered interrupt request to the CPU.
- vector_valid  out  1  one-cycle pulse after ack.
- vector_idx  out  IDX_W  acknowledged channel index.
- spurious  out  1  qualifies vector_valid: the ack found no pending request.
- irr  out  NUM_IRQ  interrupt request register.
- isr  out  NUM_IRQ  in-service register.
- lowest_prio  out  IDX_W  current lowest-priority channel.

## Operation
- Priority order: highest priority is (lowest_prio+1) mod NUM_IRQ, then ascending with wrap-around. Reset lowest_prio = NUM_IRQ-1, so channel 0 is highest.
- IRR, level mode: irr <= irq_in every cycle. IRR, edge mode: bit set on a 0->1 change of the registered irq_in copy. Bit is held until acknowledged, then cleared.
- Candidate set is irr & ~mask; the winner is the highest-priority candidate.
- Pending condition: the winner exists and has strictly higher priority than the highest-priority isr bit. An empty ISR never blocks.
- int_req <= pending; pend_idx <= winner, registered together.
- ack with int_req=1:
  - vector_idx <= pend_idx; vector_valid and spurious=0 pulse next cycle.
  - irr[pend_idx] cleared; isr[pend_idx] set unless auto_eoi.
  - auto_eoi with rotate_mode: lowest_prio <= pend_idx.
  - int_req forced 0 on that edge.
- ack with int_req=0: vector_idx <= NUM_IRQ-1 and spurious=1 with vector_valid. No state change.
- Non-specific EOI: clears the highest-priority isr bit. With rotate_mode, lowest_prio <= that index. ISR empty: no-op, no rotation.
- Specific EOI: clears isr[eoi_level]; with rotate_mode, lowest_prio <= eoi_level. eoi_level >= NUM_IRQ is ignored.
- set_prio_valid: lowest_prio <= set_prio_level. Out-of-range values are ignored.
- Simultaneous events:
  - EOI is evaluated on the pre-ack ISR; the ack's set of its bit wins over a specific EOI on the same bit.
  - set_prio_valid wins over EOI-induced rotation.
  - In edge mode, a new edge on the channel being acked keeps its irr bit set.
- Level mode, request withdrawn before ack: int_req drops the cycle after irr clears. A later ack is spurious.
- Mask changes take effect on the next int_req evaluation. A masked channel's isr bit still blocks lower priorities.

## Timing
- Reset values: irr=0, isr=0, int_req=0, vector_valid=0, vector_idx=0, spurious=0, lowest_prio=NUM_IRQ-1, irq_in edge register=0.
- irq_in to irr: 1 cycle; irq_in to int_req: 2 cycles.
- ack to vector_valid/isr/irr update: 1 cycle. int_req can reassert at the earliest 1 cycle after the ack edge.
- EOI/set_prio to isr/lowest_prio: 1 cycle. Resulting int_req change: 1 further cycle.
- Reset mid-sequence: all state returns to reset values immediately; a pending vector_valid is dropped.

## Structure
- Shared package interrupt_pkg: default NUM_IRQ, IDX_W function, spurious index constant NUM_IRQ-1.
- Sub-module rotating_priority_encoder (NUM_IRQ param): inputs vector and lowest_prio; outputs found and idx. Combinational; instantiated twice (candidates, ISR).

## Test plan
- Edge mode, reset priorities; irq_in=0x24 -> int_req after 2 cycles; ack -> vector_idx=2, isr=0x04, irr=0x20. int_req stays low until non-specific EOI, then ack -> vector_idx=5.
- Fully nested: isr=0x10 (ch4 in service), raise ch6 -> no int_req; raise ch1 -> int_req, ack -> isr=0x12.
- rotate_mode=1: ack ch3, non-specific EOI -> lowest_prio=3. Then irq 0x05 and 0x10 together -> vector_idx=4.
- set_prio_valid with level 5 and simultaneous specific EOI ch2 under rotate_mode -> lowest_prio=5, isr bit 2 cleared.
- Level mode: assert ch7, drop it before ack, ack -> vector_valid with spurious=1, vector_idx=7, isr unchanged.
- auto_eoi=1, mask=0xFE, irq 0x03 -> only ch0 acked, isr stays 0x00. rst_n pulsed mid-ack -> all outputs at reset values.
